// File: rtl/neo_pbus_pkg.sv
// Shared defaults for the P-bus latch controller: address widths, FIFO depth,
// synchroniser length and the sticky-overflow bit layout.
package neo_pbus_pkg;

  localparam int unsigned C_WIDTH_DEF     = 20;
  localparam int unsigned S_WIDTH_DEF     = 16;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  localparam int unsigned OVF_C_BIT = 0;
  localparam int unsigned OVF_S_BIT = 1;

  // Clear first, then let a same-edge overflow set its bit again
  function automatic logic [1:0] ovf_next(input logic [1:0] ovf,
                                          input logic       clr,
                                          input logic       c_drop,
                                          input logic       s_drop);
    logic [1:0] nx;
    nx            = clr ? 2'b00 : ovf;
    nx[OVF_C_BIT] = nx[OVF_C_BIT] | c_drop;
    nx[OVF_S_BIT] = nx[OVF_S_BIT] | s_drop;
    return nx;
  endfunction

endpackage

// File: rtl/pbus_req_fifo.sv
// Request FIFO with registered valid/head; push and pop may share an edge at
// any fill level, a push into a full FIFO without pop is dropped.
module pbus_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
  logic [CW-1:0]    count, count_nx;
  logic             full, pop, wr_en;
  logic [WIDTH-1:0] head_nx;

  always_comb begin
    full      = (count == CW'(DEPTH));
    pop       = valid & ready;
    wr_en     = push & (~full | pop);
    drop_c    = push & full & ~pop;
    rd_ptr_nx = pop   ? rd_ptr + AW'(1) : rd_ptr;
    wr_ptr_nx = wr_en ? wr_ptr + AW'(1) : wr_ptr;
    count_nx  = count;
    if (wr_en && !pop) begin
      count_nx = count + CW'(1);
    end else if (pop && !wr_en) begin
      count_nx = count - CW'(1);
    end
    // The incoming word becomes head when it lands exactly where the read pointer goes
    head_nx = (wr_en && (wr_ptr == rd_ptr_nx)) ? din : mem[rd_ptr_nx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      rd_ptr <= rd_ptr_nx;
      wr_ptr <= wr_ptr_nx;
      count  <= count_nx;
      valid  <= (count_nx != '0);
      dout   <= head_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pbus_latch_ctrl.sv
// Captures P-bus addresses on rising PCK1B/PCK2B strobes after synchronisation,
// holds the last value per channel and queues every capture for a consumer.
module pbus_latch_ctrl
  import neo_pbus_pkg::*;
#(
  parameter int unsigned C_WIDTH     = C_WIDTH_DEF,
  parameter int unsigned S_WIDTH     = S_WIDTH_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [C_WIDTH-1:0] PBUS,
  input  logic               PCK1B,
  input  logic               PCK2B,
  input  logic               S2H1,
  output logic [C_WIDTH-1:0] C_LATCH,
  output logic [S_WIDTH-1:0] S_LATCH,
  output logic               C_VALID,
  output logic [C_WIDTH-1:0] C_ADDR,
  input  logic               C_READY,
  output logic               S_VALID,
  output logic [S_WIDTH:0]   S_ADDR,
  input  logic               S_READY,
  output logic [1:0]         OVF,
  input  logic               OVF_CLR
);

  localparam int unsigned LAST = SYNC_STAGES - 1;
  localparam int unsigned WW   = $clog2(SYNC_STAGES + 1);
  localparam int unsigned DW   = SYNC_STAGES * C_WIDTH;

  logic [SYNC_STAGES-1:0]              pck1_sync, pck2_sync, s2h1_sync;
  logic [SYNC_STAGES-1:0][C_WIDTH-1:0] pbus_dly;
  logic [WW-1:0]                       warm_cnt;
  logic                                warm, c_prev, s_prev;
  logic                                c_evt_c, s_evt_c, c_drop_c, s_drop_c;
  logic [C_WIDTH-1:0]                  bus_d;
  logic [S_WIDTH:0]                    s_entry;

  // Edge detect only once the chains hold post-reset samples
  always_comb begin
    warm    = (warm_cnt == WW'(SYNC_STAGES));
    bus_d   = pbus_dly[LAST];
    c_evt_c = warm & pck1_sync[LAST] & ~c_prev;
    s_evt_c = warm & pck2_sync[LAST] & ~s_prev;
    s_entry = {s2h1_sync[LAST], bus_d[S_WIDTH-1:0]};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pck1_sync <= '0;
      pck2_sync <= '0;
      s2h1_sync <= '0;
      pbus_dly  <= '0;
      warm_cnt  <= '0;
      c_prev    <= 1'b1;
      s_prev    <= 1'b1;
      C_LATCH   <= '0;
      S_LATCH   <= '0;
      OVF       <= '0;
    end else begin
      pck1_sync <= SYNC_STAGES'({pck1_sync, PCK1B});
      pck2_sync <= SYNC_STAGES'({pck2_sync, PCK2B});
      s2h1_sync <= SYNC_STAGES'({s2h1_sync, S2H1});
      pbus_dly  <= DW'({pbus_dly, PBUS});
      if (!warm) begin
        warm_cnt <= warm_cnt + WW'(1);
      end
      // Holding prev high until warm means a strobe high at release is never an edge
      c_prev <= warm ? pck1_sync[LAST] : 1'b1;
      s_prev <= warm ? pck2_sync[LAST] : 1'b1;
      if (c_evt_c) begin
        C_LATCH <= bus_d;
      end
      if (s_evt_c) begin
        S_LATCH <= bus_d[S_WIDTH-1:0];
      end
      OVF <= ovf_next(OVF, OVF_CLR, c_drop_c, s_drop_c);
    end
  end

  pbus_req_fifo #(
    .WIDTH (C_WIDTH),
    .DEPTH (DEPTH)
  ) u_c_fifo (
    .clk    (CLK),
    .reset  (RESET),
    .push   (c_evt_c),
    .din    (bus_d),
    .ready  (C_READY),
    .valid  (C_VALID),
    .dout   (C_ADDR),
    .drop_c (c_drop_c)
  );

  pbus_req_fifo #(
    .WIDTH (S_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_s_fifo (
    .clk    (CLK),
    .reset  (RESET),
    .push   (s_evt_c),
    .din    (s_entry),
    .ready  (S_READY),
    .valid  (S_VALID),
    .dout   (S_ADDR),
    .drop_c (s_drop_c)
  );

endmodule

// File: tb/tb_pbus_latch_ctrl.sv
// Bench for pbus_latch_ctrl: an edge-history/queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pbus_latch_ctrl;

  localparam int unsigned CW = 20;
  localparam int unsigned SW = 16;
  localparam int unsigned DP = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned HN = 4096;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [CW-1:0] PBUS;
  logic          PCK1B, PCK2B, S2H1;
  logic [CW-1:0] C_LATCH, C_ADDR;
  logic [SW-1:0] S_LATCH;
  logic          C_VALID, C_READY, S_VALID, S_READY;
  logic [SW:0]   S_ADDR;
  logic [1:0]    OVF;
  logic          OVF_CLR;

  always #5 CLK = ~CLK;

  pbus_latch_ctrl #(
    .C_WIDTH     (CW),
    .S_WIDTH     (SW),
    .DEPTH       (DP),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .PBUS    (PBUS),
    .PCK1B   (PCK1B),
    .PCK2B   (PCK2B),
    .S2H1    (S2H1),
    .C_LATCH (C_LATCH),
    .S_LATCH (S_LATCH),
    .C_VALID (C_VALID),
    .C_ADDR  (C_ADDR),
    .C_READY (C_READY),
    .S_VALID (S_VALID),
    .S_ADDR  (S_ADDR),
    .S_READY (S_READY),
    .OVF     (OVF),
    .OVF_CLR (OVF_CLR)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw input history per edge, queues for the two FIFOs
  bit            h_rst [HN];
  bit            h_p1  [HN];
  bit            h_p2  [HN];
  bit            h_s2  [HN];
  logic [CW-1:0] h_bus [HN];
  logic [CW-1:0] mq_c [$];
  logic [SW:0]   mq_s [$];
  logic [CW-1:0] m_clatch;
  logic [SW-1:0] m_slatch;
  logic [1:0]    m_ovf;
  bit            live = 0;
  int            edge_n = 0;

  // A capture lands SS edges after the strobe is first sampled high, provided
  // it was sampled low the edge before and no reset touched that window.
  function automatic bit rose(input int k, input bit ch);
    if (k < int'(SS) + 1) return 1'b0;
    for (int j = k - int'(SS) - 1; j <= k; j++) begin
      if (h_rst[j]) return 1'b0;
    end
    if (ch) return !h_p2[k-SS-1] && h_p2[k-SS];
    return !h_p1[k-SS-1] && h_p1[k-SS];
  endfunction

  always @(posedge CLK) begin : model
    int            k;
    bit            ce, se, cpop, spop;
    logic [CW-1:0] b;
    logic [SW:0]   sv;
    k        = edge_n;
    h_rst[k] = RESET;
    h_p1[k]  = PCK1B;
    h_p2[k]  = PCK2B;
    h_s2[k]  = S2H1;
    h_bus[k] = PBUS;
    if (RESET) begin
      mq_c.delete();
      mq_s.delete();
      m_clatch = '0;
      m_slatch = '0;
      m_ovf    = '0;
      live     = 1;
    end else begin
      ce   = rose(k, 1'b0);
      se   = rose(k, 1'b1);
      cpop = (mq_c.size() != 0) && C_READY;
      spop = (mq_s.size() != 0) && S_READY;
      if (OVF_CLR) m_ovf = 2'b00;
      if (cpop) void'(mq_c.pop_front());
      if (spop) void'(mq_s.pop_front());
      if (ce) begin
        b        = h_bus[k-SS];
        m_clatch = b;
        if (mq_c.size() < DP) mq_c.push_back(b);
        else m_ovf[0] = 1'b1;
      end
      if (se) begin
        b        = h_bus[k-SS];
        sv       = {h_s2[k-SS], b[SW-1:0]};
        m_slatch = b[SW-1:0];
        if (mq_s.size() < DP) mq_s.push_back(sv);
        else m_ovf[1] = 1'b1;
      end
    end
    edge_n++;
  end

  always @(negedge CLK) begin
    if (live) begin
      cmp("m_c_valid", C_VALID, mq_c.size() != 0);
      if (mq_c.size() != 0) cmp("m_c_addr", C_ADDR, mq_c[0]);
      cmp("m_s_valid", S_VALID, mq_s.size() != 0);
      if (mq_s.size() != 0) cmp("m_s_addr", S_ADDR, mq_s[0]);
      cmp("m_c_latch", C_LATCH, m_clatch);
      cmp("m_s_latch", S_LATCH, m_slatch);
      cmp("m_ovf", OVF, m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic c_event(input logic [CW-1:0] v);
    PBUS  = v;
    PCK1B = 1'b1;
    tick(2);
    PCK1B = 1'b0;
    tick(2);
  endtask

  task automatic s_event(input logic [CW-1:0] v, input logic h);
    PBUS  = v;
    S2H1  = h;
    PCK2B = 1'b1;
    tick(2);
    PCK2B = 1'b0;
    tick(2);
  endtask

  initial begin
    RESET = 1'b1; PBUS = '0; PCK1B = 1'b0; PCK2B = 1'b0; S2H1 = 1'b0;
    C_READY = 1'b0; S_READY = 1'b0; OVF_CLR = 1'b0;
    tick(3);
    cmp("rst_c_valid", C_VALID, 0);
    cmp("rst_s_valid", S_VALID, 0);
    cmp("rst_ovf", OVF, 0);
    cmp("rst_c_latch", C_LATCH, 0);
    RESET = 1'b0;
    tick(4);

    // Single C capture: latency and single entry
    PBUS = 20'h12345; PCK1B = 1'b1;
    tick(2);
    cmp("c_lat_edge2_valid", C_VALID, 0);
    tick(1);
    cmp("c_lat_edge3_valid", C_VALID, 1);
    cmp("c_lat_latch", C_LATCH, 20'h12345);
    cmp("c_lat_addr", C_ADDR, 20'h12345);
    tick(1);
    PCK1B = 1'b0;
    tick(4);
    cmp("c_hold_valid", C_VALID, 1);
    C_READY = 1'b1;
    tick(1);
    C_READY = 1'b0;
    cmp("c_one_entry", C_VALID, 0);

    // S capture with high half select
    s_event(20'h0ABCD, 1'b1);
    tick(1);
    cmp("s_latch", S_LATCH, 16'hABCD);
    cmp("s_addr", S_ADDR, 17'h1ABCD);
    cmp("s_valid", S_VALID, 1);
    S_READY = 1'b1;
    tick(1);
    S_READY = 1'b0;
    S2H1 = 1'b0;

    // Five C captures into a depth-4 FIFO
    for (int v = 1; v <= 5; v++) c_event(20'(v));
    cmp("ovf_c_set", OVF, 2'b01);
    cmp("ovf_latch_5", C_LATCH, 20'h5);
    cmp("ovf_head_1", C_ADDR, 20'h1);
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    cmp("ovf_cleared", OVF, 2'b00);
    PBUS = 20'h6; PCK1B = 1'b1;
    tick(2);
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    cmp("ovf_set_wins", OVF, 2'b01);
    PCK1B = 1'b0;
    tick(2);
    cmp("ovf_latch_6", C_LATCH, 20'h6);
    C_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cmp("drain_c", C_ADDR, 32'(i));
      tick(1);
    end
    C_READY = 1'b0;
    cmp("drain_empty", C_VALID, 0);
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;

    // Full FIFO with pop on the push edge
    for (int v = 16; v <= 19; v++) c_event(20'(v));
    PBUS = 20'h14; PCK1B = 1'b1;
    tick(2);
    C_READY = 1'b1;
    tick(1);
    C_READY = 1'b0;
    PCK1B = 1'b0;
    cmp("full_pp_ovf", OVF, 2'b00);
    cmp("full_pp_head", C_ADDR, 20'h11);
    cmp("full_pp_latch", C_LATCH, 20'h14);
    C_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp("full_pp_drain", C_ADDR, 32'(20'h11 + i));
      tick(1);
    end
    C_READY = 1'b0;
    cmp("full_pp_empty", C_VALID, 0);

    // Simultaneous C and S strobes
    tick(1);
    PBUS = 20'h0F0F0; S2H1 = 1'b1; PCK1B = 1'b1; PCK2B = 1'b1;
    tick(2);
    PCK1B = 1'b0; PCK2B = 1'b0;
    tick(2);
    cmp("both_c_addr", C_ADDR, 20'h0F0F0);
    cmp("both_s_addr", S_ADDR, 17'h1F0F0);
    cmp("both_c_valid", C_VALID, 1);
    cmp("both_s_valid", S_VALID, 1);
    C_READY = 1'b1; S_READY = 1'b1;
    tick(1);
    C_READY = 1'b0; S_READY = 1'b0; S2H1 = 1'b0;

    // Reset with queued entries and a strobe held through release
    for (int v = 33; v <= 37; v++) s_event(20'(v), 1'b0);
    for (int v = 49; v <= 51; v++) c_event(20'(v));
    cmp("pre_rst_ovf", OVF, 2'b10);
    PBUS = 20'h77; PCK1B = 1'b1;
    tick(1);
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(6);
    cmp("post_rst_c_valid", C_VALID, 0);
    cmp("post_rst_s_valid", S_VALID, 0);
    cmp("post_rst_ovf", OVF, 0);
    cmp("post_rst_no_evt", C_LATCH, 0);
    PCK1B = 1'b0;
    tick(2);
    PCK1B = 1'b1;
    tick(3);
    cmp("rearm_valid", C_VALID, 1);
    cmp("rearm_latch", C_LATCH, 20'h77);
    PCK1B = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
